// File: rtl/tcp_misc_pkg.sv
// Purpose: shared TCP engine types: scheduler command, pend-dispatch record, command enum.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package tcp_misc_pkg;

   localparam int MAX_TCP_FLOWS = 16;
   localparam int FLOWID_W      = $clog2(MAX_TCP_FLOWS);
   localparam int SCHED_TS_W    = 16;

   // Pend-kind bit positions inside a 3-bit pend vector {ack, data, rt}.
   localparam int PEND_KINDS = 3;
   localparam int PEND_ACK   = 2;
   localparam int PEND_DATA  = 1;
   localparam int PEND_RT    = 0;

   typedef enum logic [1:0] {
      NOP   = 2'd0,
      SET   = 2'd1,
      CLEAR = 2'd2
   } sched_cmd_e;

   typedef struct packed {
      sched_cmd_e              cmd;
      logic [SCHED_TS_W-1:0]   timestamp;
   } sched_set_clear_struct;

   typedef struct packed {
      logic [FLOWID_W-1:0]     flowid;
      sched_set_clear_struct   ack_pend_set_clear;
      sched_set_clear_struct   data_pend_set_clear;
      sched_set_clear_struct   rt_pend_set_clear;
   } sched_cmd_struct;

   typedef struct packed {
      logic [FLOWID_W-1:0]     flowid;
      logic                    ack_pend;
      logic                    data_pend;
      logic                    rt_pend;
   } tx_pend_struct;

   // Next value of one pend bit under a SET/CLEAR/NOP command.
   function automatic logic apply_pend_cmd(input logic cur, input sched_cmd_e cmd);
      case (cmd)
         SET:     return 1'b1;
         CLEAR:   return 1'b0;
         default: return cur;
      endcase
   endfunction

endpackage

// File: rtl/sched_pend_table.sv
// Purpose: per-flow {ack,data,rt} pend flops with command decode and dispatch clear-mask.
// Latency: command or clear applied at the next clk edge; o_pend is the registered table.
// Backpressure: none; every command and clear is applied in the cycle it is presented.
// Ports: clk/rst; i_cmd_vld + i_cmd (one command per cycle); i_clr_vld + i_clr_flowid +
//        i_clr_mask (handshake clear of snapshotted bits); o_pend (whole table, flow-major).
module sched_pend_table
   import tcp_misc_pkg::*;
#(
   parameter int NUM_FLOWS = MAX_TCP_FLOWS
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_cmd_vld,
   input  sched_cmd_struct                       i_cmd,
   input  logic                                  i_clr_vld,
   input  logic [FLOWID_W-1:0]                   i_clr_flowid,
   input  logic [PEND_KINDS-1:0]                 i_clr_mask,
   output logic [NUM_FLOWS-1:0][PEND_KINDS-1:0]  o_pend
);

   logic [NUM_FLOWS-1:0][PEND_KINDS-1:0] r_pend;
   logic [NUM_FLOWS-1:0][PEND_KINDS-1:0] w_pend_nxt;
   sched_cmd_e                           w_kind_cmd [PEND_KINDS];
   logic                                 w_unused_ts;

   assign w_kind_cmd[PEND_ACK]  = i_cmd.ack_pend_set_clear.cmd;
   assign w_kind_cmd[PEND_DATA] = i_cmd.data_pend_set_clear.cmd;
   assign w_kind_cmd[PEND_RT]   = i_cmd.rt_pend_set_clear.cmd;

   // Timestamps are carried on the interface but not used by this revision.
   assign w_unused_ts = ^{i_cmd.ack_pend_set_clear.timestamp,
                          i_cmd.data_pend_set_clear.timestamp,
                          i_cmd.rt_pend_set_clear.timestamp};

   // The clear is applied first and the command second, so a SET or CLEAR in the
   // handshake cycle overrides the clear; NOP keeps the (possibly cleared) value.
   // A flowid >= NUM_FLOWS matches no row, so it is dropped without extra logic.
   always_comb begin
      w_pend_nxt = r_pend;
      for (int f = 0; f < NUM_FLOWS; f++) begin
         for (int k = 0; k < PEND_KINDS; k++) begin
            if (i_clr_vld && (i_clr_flowid == FLOWID_W'(f)) && i_clr_mask[k])
               w_pend_nxt[f][k] = 1'b0;
            if (i_cmd_vld && (i_cmd.flowid == FLOWID_W'(f)))
               w_pend_nxt[f][k] = apply_pend_cmd(w_pend_nxt[f][k], w_kind_cmd[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_pend <= '0;
      else     r_pend <= w_pend_nxt;
   end

   assign o_pend = r_pend;

endmodule

// File: rtl/tx_sched_pend_eng.sv
// Purpose: per-flow pend-bit scheduler; round-robin scans flows and dispatches pending ones.
// Latency: SET visible to the scanner next cycle; best case dispatch valid 2 cycles after SET.
// Backpressure: commands never stalled (rdy=1 out of reset); dispatch held until rdy.
// Ports: clk/rst; src_tx_sched_cmd_val/_data in, tx_sched_src_cmd_rdy out;
//        tx_sched_dispatch_val/_data out, dispatch_tx_sched_rdy in.
module tx_sched_pend_eng
   import tcp_misc_pkg::*;
#(
   parameter int NUM_FLOWS = MAX_TCP_FLOWS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             src_tx_sched_cmd_val,
   input  sched_cmd_struct  src_tx_sched_cmd_data,
   output logic             tx_sched_src_cmd_rdy,
   output logic             tx_sched_dispatch_val,
   output tx_pend_struct    tx_sched_dispatch_data,
   input  logic             dispatch_tx_sched_rdy
);

   typedef enum logic {
      SCAN     = 1'b0,
      DISPATCH = 1'b1
   } state_e;

   state_e                                r_state, w_state_nxt;
   logic [FLOWID_W-1:0]                   r_idx, w_idx_nxt, w_idx_inc;
   tx_pend_struct                         r_disp, w_disp_nxt;
   logic [NUM_FLOWS-1:0][PEND_KINDS-1:0]  w_pend;
   logic [PEND_KINDS-1:0]                 w_idx_pend;
   logic                                  w_cmd_acc;
   logic                                  w_hs;

   assign tx_sched_src_cmd_rdy = ~rst;
   assign w_cmd_acc            = src_tx_sched_cmd_val & tx_sched_src_cmd_rdy;

   sched_pend_table #(.NUM_FLOWS(NUM_FLOWS)) u_table (
      .clk          (clk),
      .rst          (rst),
      .i_cmd_vld    (w_cmd_acc),
      .i_cmd        (src_tx_sched_cmd_data),
      .i_clr_vld    (w_hs),
      .i_clr_flowid (r_disp.flowid),
      .i_clr_mask   ({r_disp.ack_pend, r_disp.data_pend, r_disp.rt_pend}),
      .o_pend       (w_pend)
   );

   // Row select written as a compare loop so the index width never has to match
   // the table depth exactly.
   always_comb begin
      w_idx_pend = '0;
      for (int f = 0; f < NUM_FLOWS; f++) begin
         if (r_idx == FLOWID_W'(f)) w_idx_pend = w_pend[f];
      end
   end

   assign w_idx_inc = (r_idx == FLOWID_W'(NUM_FLOWS - 1)) ? '0 : r_idx + 1'b1;

   always_comb begin
      w_state_nxt           = r_state;
      w_idx_nxt             = r_idx;
      w_disp_nxt            = r_disp;
      w_hs                  = 1'b0;
      tx_sched_dispatch_val = 1'b0;
      case (r_state)
         SCAN: begin
            if (|w_idx_pend) begin
               w_disp_nxt.flowid    = r_idx;
               w_disp_nxt.ack_pend  = w_idx_pend[PEND_ACK];
               w_disp_nxt.data_pend = w_idx_pend[PEND_DATA];
               w_disp_nxt.rt_pend   = w_idx_pend[PEND_RT];
               w_state_nxt          = DISPATCH;
            end else begin
               w_idx_nxt = w_idx_inc;
            end
         end
         DISPATCH: begin
            // Valid is gated by rst so it drops in the reset cycle itself.
            tx_sched_dispatch_val = ~rst;
            w_hs                  = ~rst & dispatch_tx_sched_rdy;
            if (w_hs) begin
               w_idx_nxt   = w_idx_inc;
               w_state_nxt = SCAN;
            end
         end
         default: w_state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SCAN;
         r_idx   <= '0;
         r_disp  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_disp  <= w_disp_nxt;
      end
   end

   assign tx_sched_dispatch_data = r_disp;

endmodule

// File: tb/tb_tx_sched_pend_eng.sv
// Purpose: self-checking bench for tx_sched_pend_eng with a behavioural pend/scan model.
// Latency: n/a.
// Backpressure: drives dispatch ready both held-low and randomised.
module tb_tx_sched_pend_eng;
   import tcp_misc_pkg::*;

   localparam int N = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_val;
   sched_cmd_struct cmd;
   logic            cmd_rdy;
   logic            tx_val;
   tx_pend_struct   tx_data;
   logic            disp_rdy;

   int vectors    = 0;
   int miscompares = 0;

   tx_pend_struct dut_log[$];
   int            model_disp_cnt = 0;

   // Reference model: pend table, scan position, outstanding snapshot.
   bit [2:0] m_tbl [N];
   int       m_idx;
   bit       m_wait;
   bit [2:0] m_snap;
   int       m_snap_flow;

   always #5 clk = ~clk;

   tx_sched_pend_eng #(.NUM_FLOWS(N)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .src_tx_sched_cmd_val   (cmd_val),
      .src_tx_sched_cmd_data  (cmd),
      .tx_sched_src_cmd_rdy   (cmd_rdy),
      .tx_sched_dispatch_val  (tx_val),
      .tx_sched_dispatch_data (tx_data),
      .dispatch_tx_sched_rdy  (disp_rdy)
   );

   function automatic tx_pend_struct mk(input int f, input bit a, input bit d, input bit r);
      tx_pend_struct p;
      p.flowid    = FLOWID_W'(f);
      p.ack_pend  = a;
      p.data_pend = d;
      p.rt_pend   = r;
      return p;
   endfunction

   function automatic sched_cmd_e kind_cmd(input sched_cmd_struct c, input int k);
      if (k == 2) return c.ack_pend_set_clear.cmd;
      if (k == 1) return c.data_pend_set_clear.cmd;
      return c.rt_pend_set_clear.cmd;
   endfunction

   function automatic void m_reset();
      for (int f = 0; f < N; f++) m_tbl[f] = 3'b000;
      m_idx = 0; m_wait = 0; m_snap = 3'b000; m_snap_flow = 0;
   endfunction

   // One clock edge of the specified behaviour, using the inputs of the ending cycle.
   function automatic void m_step();
      bit [2:0] seen;
      bit       hs;
      if (rst) begin m_reset(); return; end
      seen = m_tbl[m_idx];
      hs   = m_wait && disp_rdy;
      if (hs) m_tbl[m_snap_flow] = m_tbl[m_snap_flow] & ~m_snap;
      if (cmd_val && int'(cmd.flowid) < N) begin
         for (int k = 0; k < 3; k++) begin
            if (kind_cmd(cmd, k) == SET)   m_tbl[int'(cmd.flowid)][k] = 1'b1;
            if (kind_cmd(cmd, k) == CLEAR) m_tbl[int'(cmd.flowid)][k] = 1'b0;
         end
      end
      if (!m_wait) begin
         if (seen != 3'b000) begin
            m_wait = 1; m_snap = seen; m_snap_flow = m_idx;
         end else begin
            m_idx = (m_idx + 1) % N;
         end
      end else if (hs) begin
         m_wait = 0;
         m_idx  = (m_idx + 1) % N;
      end
   endfunction

   // Checks the current cycle's outputs against the model, then advances one clock.
   task automatic cycle();
      tx_pend_struct exp_d;
      bit            exp_val;
      #1;
      exp_val = m_wait && !rst;
      exp_d   = mk(m_snap_flow, m_snap[2], m_snap[1], m_snap[0]);
      vectors++;
      if (cmd_rdy !== !rst) begin
         miscompares++;
         $display("FAIL cmd_rdy: got %b expected %b at %0t", cmd_rdy, !rst, $time);
      end
      vectors++;
      if (tx_val !== exp_val) begin
         miscompares++;
         $display("FAIL dispatch_val: got %b expected %b at %0t", tx_val, exp_val, $time);
      end else if (exp_val && tx_data !== exp_d) begin
         miscompares++;
         $display("FAIL dispatch_data: got %h expected %h at %0t", tx_data, exp_d, $time);
      end
      if (tx_val === 1'b1 && disp_rdy && !rst) dut_log.push_back(tx_data);
      if (exp_val && disp_rdy) model_disp_cnt++;
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drive_cmd(input int flow, input sched_cmd_e a, input sched_cmd_e d,
                            input sched_cmd_e r);
      cmd_val = 1'b1;
      cmd.flowid = FLOWID_W'(flow);
      cmd.ack_pend_set_clear  = '{cmd: a, timestamp: SCHED_TS_W'($urandom)};
      cmd.data_pend_set_clear = '{cmd: d, timestamp: SCHED_TS_W'($urandom)};
      cmd.rt_pend_set_clear   = '{cmd: r, timestamp: SCHED_TS_W'($urandom)};
      cycle();
      cmd_val = 1'b0;
      cmd     = '0;
   endtask

   task automatic wait_val(input int bound, input string name);
      bit found = 0;
      for (int i = 0; i < bound; i++) begin
         if (tx_val === 1'b1) begin found = 1; break; end
         cycle();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL %s: dispatch_val not seen within %0d cycles", name, bound);
      end
   endtask

   task automatic wait_idx(input int target, input string name);
      bit found = 0;
      for (int i = 0; i < 4 * N; i++) begin
         if (m_idx == target && !m_wait) begin found = 1; break; end
         cycle();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL %s: scan position %0d not reached", name, target);
      end
   endtask

   task automatic check_log(input string name, input int n0, input int exp_cnt,
                            input tx_pend_struct e0, input tx_pend_struct e1,
                            input tx_pend_struct e2);
      tx_pend_struct exp_q[3];
      exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2;
      vectors++;
      if (dut_log.size() != n0 + exp_cnt) begin
         miscompares++;
         $display("FAIL %s count: got %0d dispatches expected %0d", name,
                  dut_log.size() - n0, exp_cnt);
      end else begin
         for (int i = 0; i < exp_cnt; i++) begin
            vectors++;
            if (dut_log[n0 + i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL %s entry %0d: got %h expected %h", name, i,
                        dut_log[n0 + i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_val = 1'b0; cmd = '0; disp_rdy = 1'b1;
      @(posedge clk);
      m_reset();
      #1;
      idle(2);
      vectors++;
      if (tx_data !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 0", tx_data);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      int n0;
      drive_cmd(5, NOP, NOP, SET);
      n0 = dut_log.size();
      wait_val(2 * N + 2, "basic_wait");
      idle(2 * N);
      check_log("basic", n0, 1, mk(5, 0, 0, 1), '0, '0);
   endtask

   task automatic test_coalesce();
      int n0;
      wait_idx((3 + N / 2) % N, "coalesce_pos");
      n0 = dut_log.size();
      drive_cmd(3, SET, NOP, NOP);
      drive_cmd(3, NOP, SET, NOP);
      idle(2 * N);
      check_log("coalesce", n0, 1, mk(3, 1, 1, 0), '0, '0);
   endtask

   task automatic test_set_at_handshake();
      int n0;
      disp_rdy = 1'b0;
      drive_cmd(7, NOP, SET, NOP);
      wait_val(2 * N + 2, "hs_wait");
      idle(10);
      n0 = dut_log.size();
      disp_rdy = 1'b1;
      drive_cmd(7, NOP, SET, NOP);
      idle(N + 2);
      check_log("set_at_hs", n0, 2, mk(7, 0, 1, 0), mk(7, 0, 1, 0), '0);
   endtask

   task automatic test_stale();
      int n0;
      disp_rdy = 1'b0;
      drive_cmd(2, SET, NOP, NOP);
      wait_val(2 * N + 2, "stale_wait");
      n0 = dut_log.size();
      drive_cmd(2, CLEAR, NOP, NOP);
      idle(3);
      disp_rdy = 1'b1;
      idle(2 * N);
      check_log("stale", n0, 1, mk(2, 1, 0, 0), '0, '0);
   endtask

   task automatic test_fairness();
      int n0;
      disp_rdy = 1'b1;
      wait_idx(2, "fair_pos");
      n0 = dut_log.size();
      drive_cmd(0, NOP, SET, NOP);
      drive_cmd(N - 1, NOP, SET, NOP);
      drive_cmd(1, NOP, SET, NOP);
      idle(3 * N);
      check_log("fairness", n0, 3, mk(N - 1, 0, 1, 0), mk(0, 0, 1, 0), mk(1, 0, 1, 0));
   endtask

   task automatic test_out_of_range();
      int n0;
      n0 = dut_log.size();
      drive_cmd(N + 1, SET, SET, SET);
      idle(2 * N);
      check_log("out_of_range", n0, 0, '0, '0, '0);
   endtask

   task automatic test_reset_mid();
      int n0;
      disp_rdy = 1'b0;
      drive_cmd(4, SET, NOP, NOP);
      drive_cmd(9, NOP, NOP, SET);
      wait_val(2 * N + 2, "rstmid_wait");
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      vectors++;
      if (tx_val !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_val: got %b expected 0", tx_val);
      end
      disp_rdy = 1'b1;
      n0 = dut_log.size();
      idle(3 * N);
      check_log("reset_mid", n0, 0, '0, '0, '0);
   endtask

   task automatic test_random();
      int n0, m0;
      n0 = dut_log.size();
      m0 = model_disp_cnt;
      for (int i = 0; i < 1500; i++) begin
         cmd_val  = ($urandom_range(0, 2) == 0);
         cmd.flowid = FLOWID_W'($urandom_range(0, (1 << FLOWID_W) - 1));
         cmd.ack_pend_set_clear  = '{cmd: sched_cmd_e'($urandom_range(0, 2)),
                                     timestamp: SCHED_TS_W'($urandom)};
         cmd.data_pend_set_clear = '{cmd: sched_cmd_e'($urandom_range(0, 2)),
                                     timestamp: SCHED_TS_W'($urandom)};
         cmd.rt_pend_set_clear   = '{cmd: sched_cmd_e'($urandom_range(0, 2)),
                                     timestamp: SCHED_TS_W'($urandom)};
         disp_rdy = ($urandom_range(0, 3) != 0);
         cycle();
      end
      cmd_val = 1'b0; cmd = '0; disp_rdy = 1'b1;
      idle(3 * N);
      vectors++;
      if (dut_log.size() - n0 != model_disp_cnt - m0) begin
         miscompares++;
         $display("FAIL random_count: got %0d dispatches expected %0d",
                  dut_log.size() - n0, model_disp_cnt - m0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_coalesce();
      test_set_at_handshake();
      test_stale();
      test_fairness();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tx_sched_pend_eng.md
# tx_sched_pend_eng

Per-flow transmit scheduler that is the consumer end of the `sched_cmd_struct` command interface. It accepts SET/CLEAR/NOP commands for the three pending kinds (ack, data, retransmit) of each flow and holds one pending bit per kind per flow. A round-robin scanner then hands flows with any pending bit to the TX pipeline as dispatch requests. It sits between the command sources (the TX timeout engine, plus the RX/app engines through an upstream mux) and the TX packet-building pipeline.

## Interface
- `NUM_FLOWS`, default `MAX_TCP_FLOWS`: number of flow slots; flow IDs are `FLOWID_W` bits wide.
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `src_tx_sched_cmd_val`  in  1  command valid.
- `src_tx_sched_cmd_data`  in  `sched_cmd_struct`  command: `flowid`, plus `{cmd, timestamp}` for each of `ack_pend_set_clear`, `data_pend_set_clear` and `rt_pend_set_clear`.
- `tx_sched_src_cmd_rdy`  out  1  command ready; constant 1 outside reset.
- `tx_sched_dispatch_val`  out  1  dispatch request valid.
- `tx_sched_dispatch_data`  out  `tx_pend_struct`  `{flowid, ack_pend, data_pend, rt_pend}`.
- `dispatch_tx_sched_rdy`  in  1  downstream accepts the dispatch.

## Operation
- **Pend table:** `NUM_FLOWS` x 3 flops, indexed by flowid.
- **Command decode:** each kind is decoded independently. `SET` sets the bit, `CLEAR` clears it, `NOP` leaves it unchanged. Timestamp fields are ignored in this revision.
- **Command acceptance:** one command is applied per cycle on `val & rdy`. Commands are never back-pressured, and a command is never dropped.
- **Scan index `idx_reg`:** `FLOWID_W` bits. It increments modulo `NUM_FLOWS`, wrapping from `NUM_FLOWS-1` to 0.
- **FSM state `SCAN`:**
  - If any pend bit of `table[idx_reg]` is 1: snapshot the three bits and `idx_reg` into `dispatch_reg`, then go to `DISPATCH`.
  - Otherwise increment `idx_reg` and stay in `SCAN`.
- **FSM state `DISPATCH`:**
  - `val = 1` and `data = dispatch_reg`. The data is stable until the handshake.
  - On `val & rdy`: clear, in `table[flowid]`, exactly the bits that are 1 in the snapshot; increment `idx_reg`; go to `SCAN`.
- **Same-cycle command and handshake:**
  - A same-cycle command has priority over the handshake clear for any bit it SETs or CLEARs.
  - So a SET that coincides with the handshake leaves the bit at 1, and the flow is re-dispatched on the next scan.
- **CLEAR of a snapshot bit while waiting in `DISPATCH`:** the table bit clears, but the outstanding dispatch is not withdrawn. The stale dispatch is delivered, and the downstream tolerates it.
- **SET of an already-snapshotted bit while waiting in `DISPATCH`:** the event coalesces into the pending dispatch and is cleared by the handshake.
- **Flags outside the snapshot:** they are never touched by the handshake.
- **Fairness:** after a dispatch the scan resumes at the next flow. Any pending flow is dispatched within `2*NUM_FLOWS` cycles of its SET, provided the downstream is always ready.

## Timing
- **Reset values:**
  - pend table all 0, `idx_reg` = 0, state `SCAN`.
  - `tx_sched_dispatch_val` = 0 and `tx_sched_dispatch_data` = 0.
  - `tx_sched_src_cmd_rdy` = 0 during reset, 1 afterwards.
- **Command latency:** a command accepted in cycle t updates the table at edge t+1. The table is visible to `SCAN` in cycle t+1.
- **Best-case dispatch latency:** a SET at cycle t for flow `idx_reg` gives `tx_sched_dispatch_val` = 1 in cycle t+2.
- **Scan rate:** one flow per cycle in `SCAN`. The handshake cycle itself also advances `idx_reg`.
- **Dispatch throughput:** at most one dispatch every 2 cycles.
- **Reset mid-dispatch:** `val` drops in the reset cycle and all pending state is lost. Upstream sources re-issue their commands.
- **Out-of-range flowid:** a command with `flowid >= NUM_FLOWS` is ignored.

## Structure
- **Shared package:** `tx_pend_struct` is added to `tcp_misc_pkg`, next to `sched_cmd_struct` and the `NOP/SET/CLEAR` enum.
- **Local to the module:** the state enum (`SCAN`, `DISPATCH`).
- **Sub-module:** `sched_pend_table`. It holds the flop array, the 3-bit command decode per kind, the clear-mask port and the priority rule. The FSM and scanner stay in the top module.

## Test plan
- **Basic dispatch:** after reset, SET rt for flowid 5 → exactly one dispatch `{5,0,0,1}`; table bit 5.rt reads 0 afterwards; `val` stays 0 thereafter.
- **Coalescing across kinds:** SET ack and data for flow 3 in consecutive cycles while `idx` is far from 3 → a single dispatch `{3,1,1,0}`.
- **SET at handshake:** hold `rdy` = 0 for 10 cycles on dispatch `{7,0,1,0}`, then SET data for flow 7 in the handshake cycle → a second dispatch for flow 7 within `NUM_FLOWS+2` cycles.
- **Stale dispatch:** dispatch `{2,1,0,0}` waits; CLEAR ack for flow 2 → the dispatch is still delivered unchanged, and no further dispatch follows.
- **Round-robin fairness:** SET data on flows 0, `NUM_FLOWS-1` and 1 with `rdy` always 1 → dispatch order follows the scan position, including across the wrap, and each flow is dispatched exactly once.
- **Reset mid-operation:** assert `rst` while `val` = 1 → `val` is 0 the next cycle; no dispatch occurs after reset without a new SET.
